// File: rtl/mul_arbiter_pkg.sv
// Shared definitions for the multiplier arbiter: state encoding, saturation limits, default width.
package mul_arbiter_pkg;

    localparam int unsigned DEFAULT_WIDTH = 11;

    localparam int SAT_MAX = 999;
    localparam int SAT_MIN = -999;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        EXEC = ST_EXEC,
        RESP = ST_RESP
    } state_t;

endpackage

// File: rtl/mul_arbiter_mul.sv
// Shared saturating signed multiplier: full product clamped to [SAT_MIN, SAT_MAX].
module mul
    import mul_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] product_c
);

    localparam int unsigned PW = 2 * WIDTH;

    logic signed [PW-1:0] prod;

    always_comb begin
        prod      = PW'(a) * PW'(b);
        product_c = prod[WIDTH-1:0];
        if (prod > PW'(SAT_MAX)) begin
            product_c = WIDTH'(SAT_MAX);
        end else if (prod < PW'(SAT_MIN)) begin
            product_c = WIDTH'(SAT_MIN);
        end
    end

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one saturating multiplier between NUM_REQ requesters.
// Optional overflow flag output enabled by defining MUL_ARB_OVF_EN.
module mul_arbiter
    import mul_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = DEFAULT_WIDTH,
    parameter int unsigned GID_W   = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   acc_in,
    input  logic [NUM_REQ*WIDTH-1:0]   arg_in,
    output logic [NUM_REQ-1:0]         ack,
    output logic signed [WIDTH-1:0]    result,
    output logic                       busy,
    output logic [GID_W-1:0]           grant_id
`ifdef MUL_ARB_OVF_EN
    ,
    output logic                       ovf
`endif
);

    // First requesting port scanning upward from last+1, wrapping at NUM_REQ.
    function automatic logic [GID_W-1:0] rr_pick(
        input logic [NUM_REQ-1:0] r,
        input logic [GID_W-1:0]   last
    );
        logic [GID_W-1:0] pick;
        logic [GID_W-1:0] idx;
        logic             found;
        pick  = '0;
        found = 1'b0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = GID_W'((32'(last) + i) % NUM_REQ);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    state_t                  state;
    logic signed [WIDTH-1:0] op_a;
    logic signed [WIDTH-1:0] op_b;
    logic [GID_W-1:0]        last_grant;
    logic signed [WIDTH-1:0] mul_y;
    logic [NUM_REQ-1:0]      req_live;
    logic [GID_W-1:0]        pick;

    // During the ack cycle the served port's req is still its old request.
    assign req_live = req & ~ack;
    assign pick     = rr_pick(req_live, last_grant);

    mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .a         (op_a),
        .b         (op_b),
        .product_c (mul_y)
    );

`ifdef MUL_ARB_OVF_EN
    localparam int unsigned PW = 2 * WIDTH;
    logic signed [PW-1:0] full_prod;
    logic                 ovf_next;

    assign full_prod = PW'(op_a) * PW'(op_b);
    assign ovf_next  = (full_prod > PW'(SAT_MAX)) || (full_prod < PW'(SAT_MIN));
`endif

    // Grant / execute / respond sequencer with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            op_a       <= '0;
            op_b       <= '0;
            last_grant <= GID_W'(NUM_REQ - 1);
            ack        <= '0;
            result     <= '0;
            busy       <= 1'b0;
            grant_id   <= '0;
`ifdef MUL_ARB_OVF_EN
            ovf        <= 1'b0;
`endif
        end else begin
            ack <= '0;
            unique case (state)
                IDLE: begin
                    if (|req_live) begin
                        op_a     <= acc_in[32'(pick)*WIDTH +: WIDTH];
                        op_b     <= arg_in[32'(pick)*WIDTH +: WIDTH];
                        grant_id <= pick;
                        busy     <= 1'b1;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    result <= mul_y;
`ifdef MUL_ARB_OVF_EN
                    ovf    <= ovf_next;
`endif
                    state  <= RESP;
                end
                RESP: begin
                    ack        <= NUM_REQ'(1) << grant_id;
                    last_grant <= grant_id;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter against a behavioural round-robin/saturation model.
// Checks the ovf output when MUL_ARB_OVF_EN is defined.
module tb_mul_arbiter;

    localparam int unsigned N = 4;
    localparam int unsigned W = 11;
    localparam int unsigned G = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [N-1:0]        req;
    logic [N*W-1:0]      acc_in;
    logic [N*W-1:0]      arg_in;
    logic [N-1:0]        ack;
    logic signed [W-1:0] result;
    logic                busy;
    logic [G-1:0]        grant_id;
`ifdef MUL_ARB_OVF_EN
    logic                ovf;
`endif

    logic signed [W-1:0] acc_v [N];
    logic signed [W-1:0] arg_v [N];

    int checks = 0;
    int errors = 0;
    int model_last;

    for (genvar gi = 0; gi < N; gi++) begin : g_pack
        assign acc_in[gi*W +: W] = acc_v[gi];
        assign arg_in[gi*W +: W] = arg_v[gi];
    end

    mul_arbiter #(
        .NUM_REQ (N),
        .WIDTH   (W),
        .GID_W   (G)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .acc_in   (acc_in),
        .arg_in   (arg_in),
        .ack      (ack),
        .result   (result),
        .busy     (busy),
        .grant_id (grant_id)
`ifdef MUL_ARB_OVF_EN
        ,
        .ovf      (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat_ref(input int a, input int b);
        int p;
        p = a * b;
        if (p > 999) return 999;
        if (p < -999) return -999;
        return p;
    endfunction

    function automatic bit ovf_ref(input int a, input int b);
        return (a * b > 999) || (a * b < -999);
    endfunction

    function automatic int next_port(input int last, input logic [N-1:0] pending);
        for (int k = 1; k <= int'(N); k++) begin
            if (pending[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic logic signed [W-1:0] rnd_operand();
        int v;
        v = int'($urandom_range(0, 2046)) - 1023;
        return W'(v);
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0;
        req   = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        model_last = N - 1;
    endtask

    // Waits for the next ack pulse; optionally drops that port's req one cycle later.
    task automatic wait_ack(input int budget, input bit drop,
                            output logic [N-1:0] ackv, output int port,
                            output int res, output int gid, output bit ov,
                            output int cycles, output bit ok);
        ok = 1'b0; cycles = 0; port = -1; ackv = '0; res = 0; gid = 0; ov = 1'b0;
        while (!ok && cycles < budget) begin
            tick();
            cycles++;
            if (ack != '0) begin
                ok   = 1'b1;
                ackv = ack;
                res  = int'(result);
                gid  = int'(grant_id);
`ifdef MUL_ARB_OVF_EN
                ov   = ovf;
`endif
                for (int i = N - 1; i >= 0; i--) if (ack[i]) port = i;
            end
        end
        if (ok && drop) begin
            tick();
            req[port] = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = '0;
        for (int i = 0; i < int'(N); i++) begin acc_v[i] = '0; arg_v[i] = '0; end
        #2;
        checks++;
        if (ack !== '0 || busy !== 1'b0 || result !== '0 || grant_id !== '0) begin
            errors++;
            $display("FAIL reset_asserted: ack=%b busy=%b result=%0d gid=%0d, required 0/0/0/0",
                     ack, busy, result, grant_id);
        end
        apply_reset();
        repeat (2) tick();
        checks++;
        if (ack !== '0 || busy !== 1'b0 || result !== '0 || grant_id !== '0) begin
            errors++;
            $display("FAIL reset_idle: ack=%b busy=%b result=%0d gid=%0d, required 0/0/0/0",
                     ack, busy, result, grant_id);
        end
`ifdef MUL_ARB_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf: got %b, required 0", ovf);
        end
`endif
    endtask

    task automatic test_single();
        logic [N-1:0] av; int p, r, g, c; bit o, ok;
        apply_reset();
        acc_v[0] = 11'sd3; arg_v[0] = 11'sd7;
        req = 4'b0001;
        tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL single_busy: got %b, required 1", busy);
        end
        wait_ack(10, 1'b1, av, p, r, g, o, c, ok);
        checks++;
        if (!ok || av !== 4'b0001 || r !== 21 || g !== 0 || c !== 2) begin
            errors++;
            $display("FAIL single_op: ok=%0b ack=%b result=%0d gid=%0d lat=%0d, required 1/0001/21/0/2",
                     ok, av, r, g, c);
        end
`ifdef MUL_ARB_OVF_EN
        checks++;
        if (o !== 1'b0) begin
            errors++;
            $display("FAIL single_ovf: got %b, required 0", o);
        end
`endif
    endtask

    task automatic test_pair();
        logic [N-1:0] av; int p, r, g, c; bit o, ok;
        apply_reset();
        acc_v[0] = -11'sd5; arg_v[0] = -11'sd17;
        acc_v[1] = -11'sd2; arg_v[1] = 11'sd421;
        req = 4'b0011;
        wait_ack(10, 1'b1, av, p, r, g, o, c, ok);
        checks++;
        if (!ok || av !== 4'b0001 || r !== 85 || g !== 0) begin
            errors++;
            $display("FAIL pair_first: ok=%0b ack=%b result=%0d gid=%0d, required 1/0001/85/0", ok, av, r, g);
        end
        wait_ack(10, 1'b1, av, p, r, g, o, c, ok);
        checks++;
        if (!ok || av !== 4'b0010 || r !== -842 || g !== 1 || c !== 2) begin
            errors++;
            $display("FAIL pair_second: ok=%0b ack=%b result=%0d gid=%0d gap=%0d, required 1/0010/-842/1/2",
                     ok, av, r, g, c);
        end
    endtask

    task automatic test_all_persistent();
        logic [N-1:0] av; int p, r, g, c, exp; bit o, ok;
        apply_reset();
        for (int i = 0; i < int'(N); i++) begin acc_v[i] = rnd_operand(); arg_v[i] = rnd_operand(); end
        req = '1;
        for (int k = 0; k < 5; k++) begin
            exp = next_port(model_last, '1);
            wait_ack(10, 1'b0, av, p, r, g, o, c, ok);
            checks++;
            if (!ok || av !== (N'(1) << exp) || g !== exp
                || r !== sat_ref(int'(acc_v[exp]), int'(arg_v[exp]))
                || (k > 0 && c !== 3)) begin
                errors++;
                $display("FAIL all_order[%0d]: ok=%0b ack=%b gid=%0d result=%0d gap=%0d, required port %0d result %0d gap 3",
                         k, ok, av, g, r, c, exp, sat_ref(int'(acc_v[exp]), int'(arg_v[exp])));
            end
`ifdef MUL_ARB_OVF_EN
            checks++;
            if (o !== ovf_ref(int'(acc_v[exp]), int'(arg_v[exp]))) begin
                errors++;
                $display("FAIL all_ovf[%0d]: got %b, required %b", k, o, ovf_ref(int'(acc_v[exp]), int'(arg_v[exp])));
            end
`endif
            if (!ok) break;
            model_last = exp;
        end
        req = '0;
    endtask

    task automatic test_single_persistent();
        logic [N-1:0] av; int p, r, g, c; bit o, ok;
        apply_reset();
        acc_v[2] = 11'sd12; arg_v[2] = -11'sd9;
        req = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            wait_ack(12, 1'b0, av, p, r, g, o, c, ok);
            checks++;
            if (!ok || av !== 4'b0100 || r !== -108 || c !== (k == 0 ? 3 : 4)) begin
                errors++;
                $display("FAIL persist[%0d]: ok=%0b ack=%b result=%0d gap=%0d, required 1/0100/-108/%0d",
                         k, ok, av, r, c, (k == 0 ? 3 : 4));
            end
            if (!ok) break;
        end
        req = '0;
    endtask

    task automatic test_saturate();
        logic [N-1:0] av; int p, r, g, c; bit o, ok;
        apply_reset();
        acc_v[2] = 11'sd136; arg_v[2] = 11'sd492;
        req = 4'b0100;
        wait_ack(10, 1'b1, av, p, r, g, o, c, ok);
        checks++;
        if (!ok || av !== 4'b0100 || r !== 999 || g !== 2) begin
            errors++;
            $display("FAIL sat_pos: ok=%0b ack=%b result=%0d gid=%0d, required 1/0100/999/2", ok, av, r, g);
        end
`ifdef MUL_ARB_OVF_EN
        checks++;
        if (o !== 1'b1) begin
            errors++;
            $display("FAIL sat_pos_ovf: got %b, required 1", o);
        end
`endif
        acc_v[3] = 11'sd844; arg_v[3] = -11'sd91;
        req = 4'b1000;
        wait_ack(10, 1'b1, av, p, r, g, o, c, ok);
        checks++;
        if (!ok || av !== 4'b1000 || r !== -999 || g !== 3) begin
            errors++;
            $display("FAIL sat_neg: ok=%0b ack=%b result=%0d gid=%0d, required 1/1000/-999/3", ok, av, r, g);
        end
`ifdef MUL_ARB_OVF_EN
        checks++;
        if (o !== 1'b1) begin
            errors++;
            $display("FAIL sat_neg_ovf: got %b, required 1", o);
        end
`endif
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] av; int p, r, g, c; bit o, ok; bit seen;
        apply_reset();
        acc_v[0] = 11'sd100; arg_v[0] = 11'sd5;
        req = 4'b0001;
        tick();
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || ack !== '0 || result !== '0 || grant_id !== '0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b ack=%b result=%0d gid=%0d, required 0/0/0/0", busy, ack, result, grant_id);
        end
        req = '0;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (ack !== '0) seen = 1'b1;
        end
        rst_n = 1'b1;
        model_last = N - 1;
        tick();
        if (ack !== '0) seen = 1'b1;
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_mid_noack: ack pulse seen after abort, required none");
        end
        acc_v[1] = 11'sd3; arg_v[1] = 11'sd7;
        req = 4'b0010;
        wait_ack(10, 1'b1, av, p, r, g, o, c, ok);
        checks++;
        if (!ok || av !== 4'b0010 || r !== 21 || g !== 1) begin
            errors++;
            $display("FAIL reset_mid_next: ok=%0b ack=%b result=%0d gid=%0d, required 1/0010/21/1", ok, av, r, g);
        end
    endtask

    task automatic test_operand_hold();
        logic [N-1:0] av; int p, r, g, c; bit o, ok;
        apply_reset();
        acc_v[0] = 11'sd10; arg_v[0] = 11'sd10;
        req = 4'b0001;
        tick();
        acc_v[0] = 11'sd500; arg_v[0] = -11'sd3;
        wait_ack(10, 1'b1, av, p, r, g, o, c, ok);
        checks++;
        if (!ok || av !== 4'b0001 || r !== 100) begin
            errors++;
            $display("FAIL operand_hold: ok=%0b ack=%b result=%0d, required 1/0001/100", ok, av, r);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] av, pending; int p, r, g, c, exp, ea, eb, cnt; bit o, ok;
        apply_reset();
        for (int b = 0; b < 12; b++) begin
            pending = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < int'(N); i++) begin acc_v[i] = rnd_operand(); arg_v[i] = rnd_operand(); end
            if (b % 3 == 0) begin acc_v[0] = 11'sd31; arg_v[0] = 11'sd32; end
            req = pending;
            cnt = $countones(pending);
            for (int k = 0; k < cnt; k++) begin
                exp = next_port(model_last, pending);
                ea  = int'(acc_v[exp]);
                eb  = int'(arg_v[exp]);
                wait_ack(12, 1'b1, av, p, r, g, o, c, ok);
                checks++;
                if (!ok || av !== (N'(1) << exp) || g !== exp || r !== sat_ref(ea, eb)) begin
                    errors++;
                    $display("FAIL random[%0d.%0d]: ok=%0b ack=%b gid=%0d result=%0d, required port %0d result %0d",
                             b, k, ok, av, g, r, exp, sat_ref(ea, eb));
                end
`ifdef MUL_ARB_OVF_EN
                checks++;
                if (o !== ovf_ref(ea, eb)) begin
                    errors++;
                    $display("FAIL random_ovf[%0d.%0d]: got %b, required %b", b, k, o, ovf_ref(ea, eb));
                end
`endif
                if (!ok) break;
                pending[exp] = 1'b0;
                model_last   = exp;
            end
            req = '0;
            repeat ($urandom_range(1, 3)) tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_pair();
        test_all_persistent();
        test_single_persistent();
        test_saturate();
        test_reset_mid();
        test_operand_hold();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
